// File: rtl/led_drv_pkg.sv
// Shared types and constants for the LED alarm driver.
package led_drv_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        FLASH  = 2'b01,
        SWEEP  = 2'b10
    } led_state_t;

    localparam int unsigned LED_W       = 10;
    localparam int unsigned FLASH_TICKS = 8;
    localparam int unsigned SWEEP_TICKS = 20;
    localparam logic [LED_W-1:0] ALL_ON = 10'h3FF;
    localparam logic [LED_W-1:0] FIRST_LED = 10'h001;

    // Step counter must hold SWEEP_TICKS-1.
    localparam int unsigned STEP_W = 5;
    localparam logic [STEP_W-1:0] FLASH_LAST = STEP_W'(FLASH_TICKS - 1);
    localparam logic [STEP_W-1:0] SWEEP_LAST = STEP_W'(SWEEP_TICKS - 1);

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle strobe every DIV clocks.
module tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Strobe is asserted while the count sits at its terminal value.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_alarm_driver.sv
// LED pin driver: PWM-dimmed passthrough normally, flash/sweep animation during an alarm.
module led_alarm_driver
    import led_drv_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 8,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [LED_W-1:0]    pio_leds,
    input  logic [PWM_BITS-1:0] dim_level,
    input  logic                alarm_active,
    input  logic                alarm_ack,
    output logic [LED_W-1:0]    led_out,
    output logic [1:0]          alarm_state,
    output logic                tick
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;

    led_state_t          state_q, state_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                alarm_q;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                ph_q, ph_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic                pwm_on, rise, exit_req;
    logic [LED_W-1:0]    pwm_pattern;

    tick_prescaler #(
        .DIV(TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    // Event decode shared by next-state and datapath logic.
    always_comb begin
        pwm_on      = (&dim_level) | (pwm_cnt_q < dim_level);
        pwm_pattern = pio_leds & {LED_W{pwm_on}};
        rise        = alarm_active & ~alarm_q;
        exit_req    = alarm_ack | ~alarm_active;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; an exit request outranks any tick-driven phase change.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NORMAL: if (rise && !alarm_ack) state_d = FLASH;
            FLASH: begin
                if (exit_req)                          state_d = NORMAL;
                else if (tick && step_q == FLASH_LAST) state_d = SWEEP;
            end
            SWEEP: begin
                if (exit_req)                          state_d = NORMAL;
                else if (tick && step_q == SWEEP_LAST) state_d = FLASH;
            end
            default: state_d = NORMAL;
        endcase
    end

    // Output datapath: LED pattern, step counter and flash phase.
    always_comb begin
        led_d  = led_q;
        step_d = step_q;
        ph_d   = ph_q;
        unique case (state_q)
            NORMAL: begin
                if (rise && !alarm_ack) begin
                    led_d  = ALL_ON;
                    step_d = '0;
                    ph_d   = 1'b0;
                end else begin
                    led_d = pwm_pattern;
                end
            end
            FLASH: begin
                if (exit_req) begin
                    led_d = pwm_pattern;
                end else if (tick) begin
                    ph_d = ~ph_q;
                    if (step_q == FLASH_LAST) begin
                        step_d = '0;
                        led_d  = FIRST_LED;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                        led_d  = ph_q ? '0 : ALL_ON;
                    end
                end
            end
            SWEEP: begin
                if (exit_req) begin
                    led_d = pwm_pattern;
                end else if (tick) begin
                    if (step_q == SWEEP_LAST) begin
                        step_d = '0;
                        ph_d   = 1'b0;
                        led_d  = ALL_ON;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                        led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
                    end
                end
            end
            default: led_d = '0;
        endcase
    end

    // Datapath registers, PWM counter and alarm edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            alarm_q   <= 1'b0;
            step_q    <= '0;
            ph_q      <= 1'b0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            alarm_q   <= alarm_active;
            step_q    <= step_d;
            ph_q      <= ph_d;
            led_q     <= led_d;
        end
    end

    assign led_out     = led_q;
    assign alarm_state = state_q;

endmodule

// File: tb/tb_led_alarm_driver.sv
// Self-checking bench for led_alarm_driver with a behavioural reference model.
module tb_led_alarm_driver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] pio = '0;
    logic [3:0] dim = '0;
    logic       act = 1'b0;
    logic       ack = 1'b0;
    logic [9:0] led_out;
    logic [1:0] alarm_state;
    logic       tick;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: time since reset, alarm mode, ticks into the current phase.
    int         m_cyc = 0;
    int         m_mode = 0;
    int         m_k = 0;
    logic       m_aq = 1'b0;
    logic [9:0] m_led = '0;

    typedef struct {
        logic [9:0] pio;
        logic [3:0] dim;
        logic [9:0] exp_led;
    } vec_t;
    vec_t tbl[8];

    led_alarm_driver #(
        .CLK_HZ  (80),
        .TICK_HZ (8),
        .PWM_BITS(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pio_leds    (pio),
        .dim_level   (dim),
        .alarm_active(act),
        .alarm_ack   (ack),
        .led_out     (led_out),
        .alarm_state (alarm_state),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_mode = 0;
        m_k    = 0;
        m_aq   = 1'b0;
        m_led  = '0;
    endtask

    // Advance the model by one clock edge using the current input values.
    task automatic model_step();
        logic       tick_now, pwm, rise;
        logic [9:0] one;
        one      = 10'h001;
        tick_now = ((m_cyc % 10) == 9);
        pwm      = (dim == 4'hF) || ((m_cyc % 16) < int'(dim));
        rise     = act && !m_aq;
        if (m_mode == 0) begin
            if (rise && !ack) begin
                m_mode = 1;
                m_k    = 0;
                m_led  = 10'h3FF;
            end else begin
                m_led = pwm ? pio : 10'h000;
            end
        end else if (ack || !act) begin
            m_mode = 0;
            m_led  = pwm ? pio : 10'h000;
        end else if (tick_now) begin
            m_k++;
            if (m_mode == 1) begin
                if (m_k == 8) begin
                    m_mode = 2;
                    m_k    = 0;
                    m_led  = 10'h001;
                end else begin
                    m_led = (m_k % 2 == 1) ? 10'h3FF : 10'h000;
                end
            end else begin
                if (m_k == 20) begin
                    m_mode = 1;
                    m_k    = 0;
                    m_led  = 10'h3FF;
                end else begin
                    m_led = one << (m_k % 10);
                end
            end
        end
        m_aq = act;
        m_cyc++;
    endtask

    // One clock: update model, take the edge, compare all outputs.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("led_out", 32'(led_out), 32'(m_led));
        chk("alarm_state", 32'(alarm_state), 32'(m_mode));
        chk("tick", 32'(tick), 32'((m_cyc % 10) == 9));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int on_cnt;
        int guard;

        tbl[0] = '{10'h2A5, 4'hF, 10'h2A5};
        tbl[1] = '{10'h15A, 4'hF, 10'h15A};
        tbl[2] = '{10'h3FF, 4'hF, 10'h3FF};
        tbl[3] = '{10'h000, 4'hF, 10'h000};
        tbl[4] = '{10'h3FF, 4'h0, 10'h000};
        tbl[5] = '{10'h201, 4'hF, 10'h201};
        tbl[6] = '{10'h2A5, 4'h0, 10'h000};
        tbl[7] = '{10'h0F0, 4'hF, 10'h0F0};

        // Reset state and passthrough.
        pio = 10'h2A5;
        dim = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led", 32'(led_out), 32'h0);
        chk("reset_state", 32'(alarm_state), 32'h0);
        chk("reset_tick", 32'(tick), 32'h0);
        reset_n = 1'b1;
        model_reset();
        cycle();
        chk("first_pass", 32'(led_out), 32'h2A5);
        for (int i = 0; i < 8; i++) begin
            pio = tbl[i].pio;
            dim = tbl[i].dim;
            cycle();
            chk("table_led", 32'(led_out), 32'(tbl[i].exp_led));
        end

        // Dimming: 4 of every 16 cycles lit, then fully off.
        pio = 10'h3FF;
        dim = 4'd4;
        cycle();
        on_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            if (led_out == 10'h3FF) on_cnt++;
        end
        chk("dim4_on_cycles", 32'(on_cnt), 32'd8);
        dim = 4'd0;
        on_cnt = 0;
        cycle();
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (led_out != 10'h000) on_cnt++;
        end
        chk("dim0_on_cycles", 32'(on_cnt), 32'd0);

        // Full alarm sequence: flash, sweep, back to flash.
        pio = 10'h2A5;
        dim = 4'hF;
        act = 1'b1;
        cycle();
        chk("alarm_enter_state", 32'(alarm_state), 32'h1);
        chk("alarm_enter_led", 32'(led_out), 32'h3FF);
        run(8 * 10 + 20 * 10 + 15);

        // Ack mid-sweep, no re-entry while held, re-arm with 0->1.
        guard = 0;
        while (!(m_mode == 2 && m_k == 5) && guard < 400) begin
            cycle();
            guard++;
        end
        chk("sweep_reached", 32'(alarm_state), 32'h2);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        chk("ack_state", 32'(alarm_state), 32'h0);
        chk("ack_led", 32'(led_out), 32'h2A5);
        run(30);
        chk("held_no_reentry", 32'(alarm_state), 32'h0);
        act = 1'b0;
        cycle();
        act = 1'b1;
        cycle();
        chk("rearm_state", 32'(alarm_state), 32'h1);

        // Simultaneous rise and ack stays in NORMAL.
        act = 1'b0;
        run(2);
        act = 1'b1;
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        chk("rise_ack_state", 32'(alarm_state), 32'h0);
        run(3);

        // Alarm drops on the 8th flash tick: exit wins over the SWEEP transition.
        act = 1'b0;
        cycle();
        act = 1'b1;
        cycle();
        guard = 0;
        while (!(m_mode == 1 && m_k == 7 && (m_cyc % 10) == 9) && guard < 400) begin
            cycle();
            guard++;
        end
        act = 1'b0;
        cycle();
        chk("drop_on_tick_state", 32'(alarm_state), 32'h0);

        // Asynchronous reset in SWEEP.
        act = 1'b1;
        cycle();
        guard = 0;
        while (!(m_mode == 2 && m_k == 3) && guard < 400) begin
            cycle();
            guard++;
        end
        chk("sweep_before_reset", 32'(alarm_state), 32'h2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_led", 32'(led_out), 32'h0);
        chk("async_reset_state", 32'(alarm_state), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        run(25);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            pio = 10'($urandom);
            if ($urandom_range(0, 9) == 0) dim = 4'($urandom);
            if ($urandom_range(0, 59) == 0) act = ~act;
            ack = ($urandom_range(0, 119) == 0);
            cycle();
        end
        ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
